sd_sector_copier: RTL and testbench
===================================

Name: sd_sector_copier

Overview:
- AXI-lite master DMA engine that copies a contiguous run of 32-bit words from a source window to a destination window.
- Typical use: a boot/asset loader reads the SD card window and writes it into system RAM, or reads RAM and writes it into the SD window.
- Sits directly upstream of the SD card AXI-lite slave and drives its AR/R (or AW/W/B) channels through the interconnect.
- One transaction outstanding at a time, because the SD slave stalls for a whole sector fetch on a miss.

Parameters:
LEN_W, 16, width of word_count and words_left.
SRC_READY_TIMEOUT, 0, cycles to wait per handshake before aborting with error; 0 disables the timeout.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset: synchronous, active-low; clock aclk.
start  in  1  one-cycle request; sampled only in IDLE.
src_addr  in  32  byte address of the first source word; bits [1:0] forced to 0.
dst_addr  in  32  byte address of the first destination word; bits [1:0] forced to 0.
word_count  in  LEN_W  number of 32-bit words to copy.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse at the end of a job, success or error.
error  out  1  sticky: set on a non-OKAY response or timeout; cleared by the next accepted start.
words_left  out  LEN_W  words still to be copied.
m_axil_araddr/arprot/arvalid/arready  out/out/in  32/3/1/1  AR channel.
m_axil_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel.
m_axil_awaddr/awprot/awvalid/awready  out/out/in  32/3/1/1  AW channel.
m_axil_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel.
m_axil_bresp/bvalid/bready  in/in/out  2/1/1  B channel.

Behaviour:
- Reset values: all valids and readies 0, busy 0, done 0, error 0, words_left 0, state IDLE, all addresses and data 0. Reset mid-job drops every valid at that edge; no further beats are issued.
- All outputs are registered. arprot and awprot are 3'b000; wstrb is 4'b1111.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, FINISH.
- IDLE:
  - On start, latch src, dst and count; clear error; set busy.
  - If word_count == 0, go to FINISH with no bus activity.
  - Otherwise go to RD_ADDR. arvalid rises the cycle after start.
  - start while busy is ignored.
- RD_ADDR: arvalid = 1 with araddr = current src. Hold until arready; arvalid and araddr are stable while waiting. On handshake, arvalid -> 0 and go to RD_DATA.
- RD_DATA:
  - rready = 1. On rvalid, capture rdata into the data buffer.
  - rresp != 2'b00: set error, go to FINISH.
  - Otherwise go to WR.
- WR:
  - awvalid and wvalid rise together on entry.
  - Each drops independently on its own handshake; the channels may complete in either order or in the same cycle.
  - When both are complete, go to WR_RESP.
- WR_RESP:
  - bready = 1. On bvalid:
    - bresp != 0: set error, go to FINISH.
    - Otherwise: src += 4, dst += 4 (modulo 2^32, wrap allowed), words_left -= 1.
  - Then go to FINISH if words_left was 1, else RD_ADDR.
- FINISH: done = 1 for exactly one cycle, busy -> 0, go to IDLE. A start in the same cycle as done is ignored.
- Timeout: active only when SRC_READY_TIMEOUT != 0. Count cycles spent waiting in any handshake state; when the count reaches the limit, drop all valids, set error, go to FINISH.
- Minimum cost per word with zero-wait slaves: 4 cycles plus slave latency. No read/write overlap, to keep SD cache ordering trivial.

Decomposition:
- Package sd_storage_pkg holds:
  - copier_state_t enum;
  - AXI_RESP_OKAY / SLVERR / DECERR constants;
  - WORD_BYTES = 4.
- No sub-module; a single FSM with counters is the natural size.

Test Plan:
- Happy path: src=0x0000_0000, dst=0x8000_0000, count=3, zero-wait slaves:
  - three AR at 0x0, 0x4, 0x8;
  - three AW/W at 0x8000_0000, 0x8000_0004, 0x8000_0008, with wdata equal to the read data;
  - done pulses once, error=0, words_left=0.
- count=0: done pulses 2 cycles after start, no valid is ever asserted, busy is high for 1 cycle.
- Backpressure: arready delayed 600 cycles (SD miss), awready arriving 3 cycles after wready:
  - araddr and arvalid stay stable while waiting;
  - the AW handshake happens after the W handshake, with no duplicate beats;
  - the copy completes correctly.
- Error: bresp=2'b10 on the 2nd word of count=4:
  - error=1, done pulses, words_left=3, no 3rd AR is issued;
  - the next start clears error.
- Wrap and reset: src=0xFFFF_FFFC, count=2: reads hit 0xFFFF_FFFC then 0x0000_0000. A reset asserted during WR clears awvalid/wvalid at that edge, and busy=0.

Source files
------------

// File: rtl/sd_sector_copier_pkg.sv
// Shared types and constants for the SD sector copier DMA engine.
package sd_storage_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_FINISH
    } copier_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
    localparam logic [31:0] WORD_BYTES      = 32'd4;

    // EXOKAY is also treated as a failure: AXI-lite has no exclusive access.
    function automatic logic resp_is_err(input logic [1:0] resp);
        case (resp)
            AXI_RESP_OKAY:                   return 1'b0;
            AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
            default:                         return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sd_sector_copier_if.sv
// AXI-lite bus between the copier (master) and the interconnect (slave).
interface sd_sector_copier_if;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready,
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready
    );
endinterface

// File: rtl/sd_sector_copier.sv
// Single-outstanding AXI-lite copy engine: read one word, write it, repeat.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; job parameters latched on accept
// RD_ADDR    | arvalid held with current source address until arready
// RD_DATA    | rready held; read word captured into the write data buffer
// WR         | awvalid/wvalid raised together, each dropped on its handshake
// WR_RESP    | bready held; addresses advance and count drops on OKAY
// FINISH     | one cycle to raise done and drop busy
module sd_sector_copier
    import sd_storage_pkg::*;
#(
    parameter int          LEN_W             = 16,
    parameter int unsigned SRC_READY_TIMEOUT = 0
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               start,
    input  logic [31:0]        src_addr,
    input  logic [31:0]        dst_addr,
    input  logic [LEN_W-1:0]   word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [LEN_W-1:0]   words_left,
    sd_sector_copier_if.master m_axil
);

    localparam bit          TO_EN    = (SRC_READY_TIMEOUT != 0);
    localparam logic [31:0] TO_LIMIT = 32'(SRC_READY_TIMEOUT);

    copier_state_t    r_state, w_state_nxt;
    logic             r_busy, r_done, r_error;
    logic [LEN_W-1:0] r_words_left;
    logic [31:0]      r_araddr, r_awaddr, r_wdata, r_timer;
    logic             r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;

    logic             w_busy_nxt, w_done_nxt, w_error_nxt;
    logic [LEN_W-1:0] w_words_left_nxt;
    logic [31:0]      w_araddr_nxt, w_awaddr_nxt, w_wdata_nxt, w_timer_nxt;
    logic             w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;

    logic w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
    logic w_wr_done, w_wait_state, w_progress, w_timeout, w_start_ok, w_last_word;

    assign w_ar_hs      = r_arvalid & m_axil.arready;
    assign w_r_hs       = r_rready  & m_axil.rvalid;
    assign w_aw_hs      = r_awvalid & m_axil.awready;
    assign w_w_hs       = r_wvalid  & m_axil.wready;
    assign w_b_hs       = r_bready  & m_axil.bvalid;
    // Write phase ends once neither channel still has an unaccepted beat.
    assign w_wr_done    = (~r_awvalid | m_axil.awready) & (~r_wvalid | m_axil.wready);
    assign w_wait_state = (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA) ||
                          (r_state == ST_WR)      || (r_state == ST_WR_RESP);
    assign w_progress   = w_ar_hs | w_r_hs | w_aw_hs | w_w_hs | w_b_hs;
    assign w_timeout    = TO_EN && w_wait_state && !w_progress && (r_timer == 32'd1);
    // done is high while back in IDLE, so a start coinciding with it is dropped.
    assign w_start_ok   = (r_state == ST_IDLE) && start && !r_done;
    assign w_last_word  = (r_words_left == LEN_W'(1));

    // State and all registered outputs, synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words_left <= '0;
            r_araddr     <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awaddr     <= '0;
            r_awvalid    <= 1'b0;
            r_wdata      <= '0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_timer      <= TO_LIMIT;
        end else begin
            r_state      <= w_state_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_words_left <= w_words_left_nxt;
            r_araddr     <= w_araddr_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_awaddr     <= w_awaddr_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    // Next-state selection from handshakes, responses and the timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok)
                    w_state_nxt = (word_count == '0) ? ST_FINISH : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                if (w_timeout)    w_state_nxt = ST_FINISH;
                else if (w_ar_hs) w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (w_timeout)   w_state_nxt = ST_FINISH;
                else if (w_r_hs) w_state_nxt = resp_is_err(m_axil.rresp) ? ST_FINISH : ST_WR;
            end
            ST_WR: begin
                if (w_timeout)      w_state_nxt = ST_FINISH;
                else if (w_wr_done) w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (w_timeout) w_state_nxt = ST_FINISH;
                else if (w_b_hs)
                    w_state_nxt = (resp_is_err(m_axil.bresp) || w_last_word) ? ST_FINISH : ST_RD_ADDR;
            end
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_error_nxt      = r_error;
        w_words_left_nxt = r_words_left;
        w_araddr_nxt     = r_araddr;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_awaddr_nxt     = r_awaddr;
        w_awvalid_nxt    = r_awvalid;
        w_wdata_nxt      = r_wdata;
        w_wvalid_nxt     = r_wvalid;
        w_bready_nxt     = r_bready;
        w_timer_nxt      = (TO_EN && w_wait_state && !w_progress) ? r_timer - 32'd1 : TO_LIMIT;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_araddr_nxt     = src_addr & ~32'd3;
                    w_awaddr_nxt     = dst_addr & ~32'd3;
                    w_words_left_nxt = word_count;
                    w_error_nxt      = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_arvalid_nxt    = (word_count != '0);
                end
            end
            ST_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    w_rready_nxt = 1'b0;
                    w_wdata_nxt  = m_axil.rdata;
                    if (resp_is_err(m_axil.rresp)) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (w_aw_hs)   w_awvalid_nxt = 1'b0;
                if (w_w_hs)    w_wvalid_nxt  = 1'b0;
                if (w_wr_done) w_bready_nxt  = 1'b1;
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    w_bready_nxt = 1'b0;
                    if (resp_is_err(m_axil.bresp)) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_araddr_nxt     = r_araddr + WORD_BYTES;
                        w_awaddr_nxt     = r_awaddr + WORD_BYTES;
                        w_words_left_nxt = r_words_left - LEN_W'(1);
                        w_arvalid_nxt    = !w_last_word;
                    end
                end
            end
            ST_FINISH: begin
                w_done_nxt = 1'b1;
                w_busy_nxt = 1'b0;
            end
            default: ;
        endcase
        if (w_timeout) begin
            w_arvalid_nxt = 1'b0;
            w_rready_nxt  = 1'b0;
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
            w_bready_nxt  = 1'b0;
            w_error_nxt   = 1'b1;
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign error          = r_error;
    assign words_left     = r_words_left;
    assign m_axil.araddr  = r_araddr;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.rready  = r_rready;
    assign m_axil.awaddr  = r_awaddr;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = 4'b1111;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;

endmodule

// File: tb/tb_sd_sector_copier.sv
// Directed bench for sd_sector_copier: AXI-lite slave model, beat scoreboard
// built from each job's parameters, and literal spot checks.
module tb_sd_sector_copier;
    import sd_storage_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_addr = '0;
    logic [31:0] dst_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, error;
    logic [15:0] words_left;

    sd_sector_copier_if m_if ();

    sd_sector_copier #(.LEN_W(16), .SRC_READY_TIMEOUT(0)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_left (words_left),
        .m_axil     (m_if)
    );

    always #5 aclk = ~aclk;

    int vectors = 0;
    int miscompares = 0;

    // expected beats and observed beats
    logic [31:0] exp_ar[$], exp_aw[$], exp_w[$];
    logic [31:0] obs_ar[$], obs_aw[$], obs_w[$];
    int          done_cnt = 0;
    int          cyc_now = 0;
    int          last_aw_cyc = 0, last_w_cyc = 0;
    logic        job_err;
    logic [15:0] job_wl;

    // slave configuration / state
    int   ar_delay = 0, aw_delay = 0, w_delay = 0;
    int   bad_b = 0, b_idx = 0;
    int   ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    bit   aw_got = 0, w_got = 0;
    logic nx_arready, nx_rvalid, nx_awready, nx_wready, nx_bvalid;
    logic [31:0] nx_rdata;
    logic [1:0]  nx_bresp;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5EC7_0A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endtask

    // AXI-lite slave: decide on the falling edge, drive just after the rising edge
    initial begin
        m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = '0; m_if.rresp = AXI_RESP_OKAY;
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = AXI_RESP_OKAY;
        forever begin
            @(negedge aclk);
            nx_arready = m_if.arready; nx_rvalid = m_if.rvalid; nx_rdata = m_if.rdata;
            nx_awready = m_if.awready; nx_wready = m_if.wready;
            nx_bvalid = m_if.bvalid; nx_bresp = m_if.bresp;
            if (!aresetn) begin
                nx_arready = 0; nx_rvalid = 0; nx_awready = 0; nx_wready = 0; nx_bvalid = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; aw_got = 0; w_got = 0;
            end else begin
                if (m_if.rvalid && m_if.rready) nx_rvalid = 0;
                if (m_if.arvalid && m_if.arready) begin
                    nx_arready = (ar_delay == 0); ar_cnt = 0;
                    nx_rvalid = 1; nx_rdata = mem_word(m_if.araddr);
                end else if (m_if.arvalid) begin
                    ar_cnt++;
                    if (ar_cnt >= ar_delay) nx_arready = 1;
                end else nx_arready = (ar_delay == 0);
                if (m_if.awvalid && m_if.awready) begin
                    nx_awready = (aw_delay == 0); aw_cnt = 0; aw_got = 1;
                end else if (m_if.awvalid) begin
                    aw_cnt++;
                    if (aw_cnt >= aw_delay) nx_awready = 1;
                end else nx_awready = (aw_delay == 0);
                if (m_if.wvalid && m_if.wready) begin
                    nx_wready = (w_delay == 0); w_cnt = 0; w_got = 1;
                end else if (m_if.wvalid) begin
                    w_cnt++;
                    if (w_cnt >= w_delay) nx_wready = 1;
                end else nx_wready = (w_delay == 0);
                if (m_if.bvalid && m_if.bready) nx_bvalid = 0;
                if (aw_got && w_got) begin
                    b_idx++;
                    nx_bvalid = 1;
                    nx_bresp = (b_idx == bad_b) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                    aw_got = 0; w_got = 0;
                end
            end
            @(posedge aclk);
            #1;
            m_if.arready = nx_arready; m_if.rvalid = nx_rvalid; m_if.rdata = nx_rdata;
            m_if.rresp = AXI_RESP_OKAY;
            m_if.awready = nx_awready; m_if.wready = nx_wready;
            m_if.bvalid = nx_bvalid; m_if.bresp = nx_bresp;
        end
    end

    // compare process: every beat against the scoreboard, plus bus rules
    logic        prev_ar_wait = 0;
    logic [31:0] prev_araddr = '0;
    initial begin
        forever begin
            @(negedge aclk);
            cyc_now++;
            if (!aresetn) begin
                prev_ar_wait = 0;
                continue;
            end
            if (prev_ar_wait) begin
                chk("ar_hold_valid", 32'(m_if.arvalid), 32'd1);
                chk("ar_hold_addr", m_if.araddr, prev_araddr);
            end
            prev_ar_wait = m_if.arvalid && !m_if.arready;
            prev_araddr  = m_if.araddr;
            if (m_if.arvalid || m_if.awvalid || m_if.wvalid)
                chk("valid_needs_busy", 32'(busy), 32'd1);
            if (m_if.arvalid && m_if.arready) begin
                obs_ar.push_back(m_if.araddr);
                chk("arprot", 32'(m_if.arprot), 32'd0);
                if (exp_ar.size() == 0) miss("ar_beat", $sformatf("unexpected AR at %h", m_if.araddr));
                else chk("ar_addr", m_if.araddr, exp_ar.pop_front());
            end
            if (m_if.awvalid && m_if.awready) begin
                obs_aw.push_back(m_if.awaddr);
                last_aw_cyc = cyc_now;
                chk("awprot", 32'(m_if.awprot), 32'd0);
                if (exp_aw.size() == 0) miss("aw_beat", $sformatf("unexpected AW at %h", m_if.awaddr));
                else chk("aw_addr", m_if.awaddr, exp_aw.pop_front());
            end
            if (m_if.wvalid && m_if.wready) begin
                obs_w.push_back(m_if.wdata);
                last_w_cyc = cyc_now;
                chk("wstrb", 32'(m_if.wstrb), 32'hF);
                if (exp_w.size() == 0) miss("w_beat", $sformatf("unexpected W data %h", m_if.wdata));
                else chk("w_data", m_if.wdata, exp_w.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    // Build the expected job outcome, then pulse start for one cycle.
    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input int n, input int bad);
        int beats;
        logic [31:0] sa, da;
        sa = s & ~32'd3;
        da = d & ~32'd3;
        beats = (bad > 0 && bad <= n) ? bad : n;
        for (int i = 0; i < beats; i++) begin
            exp_ar.push_back(sa + 32'(4 * i));
            exp_aw.push_back(da + 32'(4 * i));
            exp_w.push_back(mem_word(sa + 32'(4 * i)));
        end
        job_err = (bad > 0 && bad <= n);
        job_wl  = job_err ? 16'(n - bad + 1) : 16'd0;
        obs_ar.delete(); obs_aw.delete(); obs_w.delete();
        done_cnt = 0; b_idx = 0; bad_b = bad;
        @(negedge aclk);
        src_addr = s; dst_addr = d; word_count = 16'(n); start = 1;
        @(negedge aclk);
        start = 0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err_clr", 32'(error), 32'd0);
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            @(negedge aclk);
            k++;
        end
        if (!done) miss("done_wait", $sformatf("no done within %0d cycles", limit));
        repeat (3) @(negedge aclk);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_error", 32'(error), 32'(job_err));
        chk("end_words_left", 32'(words_left), 32'(job_wl));
        chk("ar_missing", 32'(exp_ar.size()), 32'd0);
        chk("aw_missing", 32'(exp_aw.size()), 32'd0);
        chk("w_missing", 32'(exp_w.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // reset values
        repeat (4) @(negedge aclk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words_left", 32'(words_left), 32'd0);
        chk("rst_arvalid", 32'(m_if.arvalid), 32'd0);
        chk("rst_rready", 32'(m_if.rready), 32'd0);
        chk("rst_awvalid", 32'(m_if.awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_if.wvalid), 32'd0);
        chk("rst_bready", 32'(m_if.bready), 32'd0);
        chk("rst_araddr", m_if.araddr, 32'd0);
        chk("rst_awaddr", m_if.awaddr, 32'd0);
        chk("rst_wdata", m_if.wdata, 32'd0);
        aresetn = 1;

        // happy path, zero-wait slave
        start_job(32'h0000_0000, 32'h8000_0000, 3, 0);
        chk("happy_arvalid_rise", 32'(m_if.arvalid), 32'd1);
        wait_done(200);
        chk("happy_nbeats", 32'(obs_aw.size()), 32'd3);
        if (obs_aw.size() == 3) begin
            chk("happy_ar2", obs_ar[2], 32'h0000_0008);
            chk("happy_aw1", obs_aw[1], 32'h8000_0004);
            chk("happy_w2", obs_w[2], 32'h5EC7_0A52);
        end

        // zero-length job and start coinciding with done
        start_job(32'h0000_1000, 32'h0000_2000, 0, 0);
        chk("zero_done_early", 32'(done), 32'd0);
        chk("zero_no_arvalid", 32'(m_if.arvalid), 32'd0);
        @(negedge aclk);
        chk("zero_busy_drop", 32'(busy), 32'd0);
        chk("zero_done", 32'(done), 32'd1);
        word_count = 16'd5; start = 1;
        @(negedge aclk);
        start = 0;
        chk("done_start_ignored", 32'(busy), 32'd0);
        chk("zero_done_once", 32'(done), 32'd0);
        @(negedge aclk);
        chk("zero_no_arvalid2", 32'(m_if.arvalid), 32'd0);
        chk("zero_done_cnt", 32'(done_cnt), 32'd1);

        // backpressure: SD miss on AR, AW accepted after W
        ar_delay = 600; aw_delay = 3; w_delay = 0;
        start_job(32'h0000_0100, 32'h0000_2000, 2, 0);
        repeat (100) @(negedge aclk);
        src_addr = 32'h7777_0000; word_count = 16'd9; start = 1;
        @(negedge aclk);
        start = 0;
        wait_done(3000);
        chk("bp_w_before_aw", 32'(last_w_cyc < last_aw_cyc), 32'd1);
        chk("bp_nbeats", 32'(obs_ar.size()), 32'd2);
        ar_delay = 0; aw_delay = 0;

        // write response error on the second of four words
        start_job(32'h0000_0040, 32'h0000_0300, 4, 2);
        wait_done(300);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_words_left", 32'(words_left), 32'd3);
        chk("err_no_third_ar", 32'(obs_ar.size()), 32'd2);

        // next start clears the sticky error
        start_job(32'h0000_0000, 32'h0000_4000, 1, 0);
        wait_done(200);

        // address wrap
        start_job(32'hFFFF_FFFC, 32'h0000_0500, 2, 0);
        wait_done(200);
        chk("wrap_nbeats", 32'(obs_ar.size()), 32'd2);
        if (obs_ar.size() == 2) begin
            chk("wrap_ar0", obs_ar[0], 32'hFFFF_FFFC);
            chk("wrap_ar1", obs_ar[1], 32'h0000_0000);
            chk("wrap_w0", obs_w[0], 32'hA138_F5A6);
        end

        // reset while the write phase is pending
        aw_delay = 20; w_delay = 20;
        start_job(32'h0000_0080, 32'h0000_0600, 3, 0);
        k = 0;
        while (!m_if.awvalid && k < 100) begin
            @(negedge aclk);
            k++;
        end
        chk("rst_reached_wr", 32'(m_if.awvalid), 32'd1);
        aresetn = 0;
        @(negedge aclk);
        chk("midrst_awvalid", 32'(m_if.awvalid), 32'd0);
        chk("midrst_wvalid", 32'(m_if.wvalid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_words_left", 32'(words_left), 32'd0);
        @(negedge aclk);
        aresetn = 1;
        exp_ar.delete(); exp_aw.delete(); exp_w.delete();
        done_cnt = 0;
        repeat (10) @(negedge aclk);
        chk("postrst_arvalid", 32'(m_if.arvalid), 32'd0);
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_no_done", 32'(done_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
